// File: rtl/rule_match_engine_if.sv
// Shared header types and the config/packet/result bus of the rule match engine.
// The package travels with the interface so both ends agree on the packed layouts.
package rule_match_pkg;
    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] port;
    } endpoint_s;

    typedef struct packed {
        logic [7:0] protocol;
        endpoint_s  src;
        endpoint_s  dst;
    } packet_s;

    typedef struct packed {
        packet_s start;
        packet_s last;
    } rule_s;
endpackage

interface rule_match_engine_if
    import rule_match_pkg::*;
#(
    parameter int NUM_RULES = 16
);
    localparam int IDX_W = $clog2(NUM_RULES);

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    rule_s            cfg_rule;
    logic             cfg_en;
    logic             cfg_ready;

    logic             pkt_valid;
    logic             pkt_ready;
    packet_s          pkt;

    logic             res_valid;
    logic             res_ready;
    logic             res_hit;
    logic [IDX_W-1:0] res_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_rule, cfg_en,
        output pkt_valid, pkt, res_ready,
        input  cfg_ready, pkt_ready, res_valid, res_hit, res_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_rule, cfg_en,
        input  pkt_valid, pkt, res_ready,
        output cfg_ready, pkt_ready, res_valid, res_hit, res_idx
    );
endinterface

// File: rtl/rule_match_engine.sv
// Packet classifier: scans a rule table LANES entries per cycle and reports the
// lowest-indexed enabled rule whose five field ranges all contain the packet.
module rule_match_engine
    import rule_match_pkg::*;
#(
    parameter int NUM_RULES       = 16,
    parameter int LANES           = 4,
    parameter bit UPPER_INCLUSIVE = 1'b0
) (
    input logic                clk,
    input logic                rst_n,
    rule_match_engine_if.slave bus
);
    localparam int IDX_W      = $clog2(NUM_RULES);
    localparam int NUM_CHUNKS = NUM_RULES / LANES;
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CHUNK_W-1:0] chunk_q;
    logic [CHUNK_W-1:0] chunk_d;
    logic               res_hit_q;
    logic               res_hit_d;
    logic [IDX_W-1:0]   res_idx_q;
    logic [IDX_W-1:0]   res_idx_d;

    packet_s            pkt_q;
    rule_s              rule_table [NUM_RULES];
    logic [NUM_RULES-1:0] rule_en;

    logic               cfg_write;
    logic               accept_pkt;
    logic [LANES-1:0]   lane_hit;
    logic               any_hit;
    logic [IDX_W-1:0]   hit_idx;

    // Empty ranges fall out naturally: no value satisfies lo <= v < hi when lo >= hi.
    function automatic logic field_in_range(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        if (UPPER_INCLUSIVE)
            return (lo <= v) && (v <= hi);
        return (lo <= v) && (v < hi);
    endfunction

    function automatic logic rule_matches(input rule_s r, input packet_s p);
        return field_in_range(32'(p.protocol), 32'(r.start.protocol), 32'(r.last.protocol))
            && field_in_range(p.src.ip, r.start.src.ip, r.last.src.ip)
            && field_in_range(32'(p.src.port), 32'(r.start.src.port), 32'(r.last.src.port))
            && field_in_range(p.dst.ip, r.start.dst.ip, r.last.dst.ip)
            && field_in_range(32'(p.dst.port), 32'(r.start.dst.port), 32'(r.last.dst.port));
    endfunction

    function automatic logic [IDX_W-1:0] lane_index(input logic [CHUNK_W-1:0] chunk,
                                                    input int lane);
        return IDX_W'(int'(chunk) * LANES + lane);
    endfunction

    assign cfg_write     = bus.cfg_we && bus.cfg_ready;
    assign accept_pkt    = bus.pkt_valid && bus.pkt_ready;

    assign bus.cfg_ready = (state_q == IDLE);
    assign bus.pkt_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_hit   = res_hit_q;
    assign bus.res_idx   = res_idx_q;

    always_comb begin
        lane_hit = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_hit[l] = rule_en[lane_index(chunk_q, l)]
                       && rule_matches(rule_table[lane_index(chunk_q, l)], pkt_q);
        end
    end

    // Walk downwards so the lowest matching lane is the one left selected.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_hit[l]) begin
                any_hit = 1'b1;
                hit_idx = lane_index(chunk_q, l);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        chunk_d   = chunk_q;
        res_hit_d = res_hit_q;
        res_idx_d = res_idx_q;
        case (state_q)
            IDLE: begin
                if (bus.pkt_valid) begin
                    chunk_d = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (any_hit) begin
                    res_hit_d = 1'b1;
                    res_idx_d = hit_idx;
                    chunk_d   = '0;
                    state_d   = DONE;
                end else if (chunk_q == LAST_CHUNK) begin
                    res_hit_d = 1'b0;
                    res_idx_d = '0;
                    chunk_d   = '0;
                    state_d   = DONE;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            chunk_q   <= '0;
            res_hit_q <= 1'b0;
            res_idx_q <= '0;
            rule_en   <= '0;
        end else begin
            state_q   <= state_d;
            chunk_q   <= chunk_d;
            res_hit_q <= res_hit_d;
            res_idx_q <= res_idx_d;
            if (cfg_write)
                rule_en[bus.cfg_addr] <= bus.cfg_en;
        end
    end

    // Bounds and the latched header are qualified by rule_en and the FSM, so they carry no reset.
    always_ff @(posedge clk) begin
        if (cfg_write)
            rule_table[bus.cfg_addr] <= bus.cfg_rule;
        if (accept_pkt)
            pkt_q <= bus.pkt;
    end
endmodule

// File: tb/tb_rule_match_engine.sv
// Directed bench: an exclusive-bound and an inclusive-bound engine see identical traffic
// and each result is checked against hand-computed hit, index and latency.
module tb_rule_match_engine;
    import rule_match_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rule_match_engine_if #(.NUM_RULES(16)) bus_ex ();
    rule_match_engine_if #(.NUM_RULES(16)) bus_in ();

    rule_match_engine #(.NUM_RULES(16), .LANES(4), .UPPER_INCLUSIVE(1'b0)) dut_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_ex)
    );

    rule_match_engine #(.NUM_RULES(16), .LANES(4), .UPPER_INCLUSIVE(1'b1)) dut_in (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_in)
    );

    assign bus_in.cfg_we    = bus_ex.cfg_we;
    assign bus_in.cfg_addr  = bus_ex.cfg_addr;
    assign bus_in.cfg_rule  = bus_ex.cfg_rule;
    assign bus_in.cfg_en    = bus_ex.cfg_en;
    assign bus_in.pkt_valid = bus_ex.pkt_valid;
    assign bus_in.pkt       = bus_ex.pkt;
    assign bus_in.res_ready = bus_ex.res_ready;

    int         assert_count = 0;
    int         fail_count   = 0;
    int         lat_ex;
    int         lat_in;
    logic       hit_ex;
    logic       hit_in;
    logic [3:0] idx_ex;
    logic [3:0] idx_in;
    logic       seen;
    rule_s      broad;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic packet_s make_pkt(input logic [15:0] dport);
        packet_s p;
        p.protocol = 8'd6;
        p.src.ip   = 32'h0A00_0001;
        p.src.port = 16'd1234;
        p.dst.ip   = 32'hC0A8_0001;
        p.dst.port = dport;
        return p;
    endfunction

    function automatic rule_s make_rule(input logic [15:0] lo, input logic [15:0] hi);
        rule_s r;
        r.start.protocol = 8'h00;
        r.last.protocol  = 8'hFF;
        r.start.src.ip   = 32'h0;
        r.last.src.ip    = 32'hFFFF_FFFF;
        r.start.src.port = 16'h0;
        r.last.src.port  = 16'hFFFF;
        r.start.dst.ip   = 32'h0;
        r.last.dst.ip    = 32'hFFFF_FFFF;
        r.start.dst.port = lo;
        r.last.dst.port  = hi;
        return r;
    endfunction

    task automatic write_rule(input logic [3:0] addr, input rule_s r, input logic en);
        @(negedge clk);
        bus_ex.cfg_we   = 1'b1;
        bus_ex.cfg_addr = addr;
        bus_ex.cfg_rule = r;
        bus_ex.cfg_en   = en;
        @(negedge clk);
        bus_ex.cfg_we   = 1'b0;
    endtask

    // Latency n means res_valid was first seen after the n-th edge following acceptance.
    task automatic applyStimulus(input packet_s p);
        lat_ex = -1;
        lat_in = -1;
        hit_ex = 1'b0;
        hit_in = 1'b0;
        idx_ex = '0;
        idx_in = '0;
        @(negedge clk);
        bus_ex.pkt       = p;
        bus_ex.pkt_valid = 1'b1;
        bus_ex.res_ready = 1'b1;
        @(negedge clk);
        bus_ex.pkt_valid = 1'b0;
        for (int n = 1; n <= 12 && (lat_ex < 0 || lat_in < 0); n++) begin
            @(negedge clk);
            if (lat_ex < 0 && bus_ex.res_valid) begin
                lat_ex = n;
                hit_ex = bus_ex.res_hit;
                idx_ex = bus_ex.res_idx;
            end
            if (lat_in < 0 && bus_in.res_valid) begin
                lat_in = n;
                hit_in = bus_in.res_hit;
                idx_in = bus_in.res_idx;
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus_ex.cfg_we    = 1'b0;
        bus_ex.cfg_addr  = '0;
        bus_ex.cfg_rule  = '0;
        bus_ex.cfg_en    = 1'b0;
        bus_ex.pkt_valid = 1'b0;
        bus_ex.pkt       = '0;
        bus_ex.res_ready = 1'b0;
        broad            = make_rule(16'h0000, 16'hFFFF);

        repeat (3) @(negedge clk);
        checkOutput("reset_pkt_ready", 32'(bus_ex.pkt_ready), 32'd1);
        checkOutput("reset_cfg_ready", 32'(bus_ex.cfg_ready), 32'd1);
        checkOutput("reset_res_valid", 32'(bus_ex.res_valid), 32'd0);
        checkOutput("reset_res_hit", 32'(bus_ex.res_hit), 32'd0);
        checkOutput("reset_res_idx", 32'(bus_ex.res_idx), 32'd0);
        checkOutput("reset_in_pkt_ready", 32'(bus_in.pkt_ready), 32'd1);
        rst_n = 1'b1;

        applyStimulus(make_pkt(16'd80));
        checkOutput("empty_lat", 32'(lat_ex), 32'd4);
        checkOutput("empty_hit", 32'(hit_ex), 32'd0);
        checkOutput("empty_idx", 32'(idx_ex), 32'd0);

        write_rule(4'd5, broad, 1'b1);
        write_rule(4'd9, broad, 1'b1);
        applyStimulus(make_pkt(16'd80));
        checkOutput("prio_hit", 32'(hit_ex), 32'd1);
        checkOutput("prio_idx", 32'(idx_ex), 32'd5);
        checkOutput("prio_lat", 32'(lat_ex), 32'd2);
        checkOutput("prio_in_idx", 32'(idx_in), 32'd5);

        write_rule(4'd0, broad, 1'b1);
        applyStimulus(make_pkt(16'd80));
        checkOutput("rule0_idx", 32'(idx_ex), 32'd0);
        checkOutput("rule0_hit", 32'(hit_ex), 32'd1);
        checkOutput("rule0_lat", 32'(lat_ex), 32'd1);
        write_rule(4'd0, broad, 1'b0);
        write_rule(4'd5, broad, 1'b0);
        write_rule(4'd9, broad, 1'b0);

        write_rule(4'd3, make_rule(16'd80, 16'd81), 1'b1);
        applyStimulus(make_pkt(16'd80));
        checkOutput("lo_edge_hit", 32'(hit_ex), 32'd1);
        checkOutput("lo_edge_idx", 32'(idx_ex), 32'd3);
        checkOutput("lo_edge_lat", 32'(lat_ex), 32'd1);
        applyStimulus(make_pkt(16'd81));
        checkOutput("hi_edge_ex_hit", 32'(hit_ex), 32'd0);
        checkOutput("hi_edge_ex_lat", 32'(lat_ex), 32'd4);
        checkOutput("hi_edge_in_hit", 32'(hit_in), 32'd1);
        checkOutput("hi_edge_in_idx", 32'(idx_in), 32'd3);
        checkOutput("hi_edge_in_lat", 32'(lat_in), 32'd1);
        write_rule(4'd3, make_rule(16'd80, 16'd80), 1'b1);
        applyStimulus(make_pkt(16'd80));
        checkOutput("eq_bounds_ex_hit", 32'(hit_ex), 32'd0);
        checkOutput("eq_bounds_in_hit", 32'(hit_in), 32'd1);
        write_rule(4'd3, make_rule(16'd81, 16'd80), 1'b1);
        applyStimulus(make_pkt(16'd80));
        checkOutput("inverted_ex_hit", 32'(hit_ex), 32'd0);
        checkOutput("inverted_in_hit", 32'(hit_in), 32'd0);
        write_rule(4'd3, broad, 1'b0);

        write_rule(4'd7, broad, 1'b0);
        applyStimulus(make_pkt(16'd80));
        checkOutput("disabled_hit", 32'(hit_ex), 32'd0);
        write_rule(4'd7, broad, 1'b1);
        applyStimulus(make_pkt(16'd80));
        checkOutput("enabled_hit", 32'(hit_ex), 32'd1);
        checkOutput("enabled_idx", 32'(idx_ex), 32'd7);
        checkOutput("enabled_lat", 32'(lat_ex), 32'd2);

        // Result held under backpressure while a table write is attempted.
        write_rule(4'd2, make_rule(16'd80, 16'd81), 1'b1);
        @(negedge clk);
        bus_ex.pkt       = make_pkt(16'd80);
        bus_ex.pkt_valid = 1'b1;
        bus_ex.res_ready = 1'b0;
        @(negedge clk);
        bus_ex.pkt_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            seen = bus_ex.res_valid;
        end
        checkOutput("hold_reached_done", 32'(seen), 32'd1);
        bus_ex.cfg_we   = 1'b1;
        bus_ex.cfg_addr = 4'd2;
        bus_ex.cfg_rule = make_rule(16'd90, 16'd91);
        bus_ex.cfg_en   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(bus_ex.res_valid), 32'd1);
            checkOutput("hold_hit", 32'(bus_ex.res_hit), 32'd1);
            checkOutput("hold_idx", 32'(bus_ex.res_idx), 32'd2);
            checkOutput("hold_pkt_ready", 32'(bus_ex.pkt_ready), 32'd0);
        end
        checkOutput("hold_cfg_ready", 32'(bus_ex.cfg_ready), 32'd0);
        bus_ex.cfg_we    = 1'b0;
        bus_ex.res_ready = 1'b1;
        @(negedge clk);
        checkOutput("hold_released", 32'(bus_ex.res_valid), 32'd0);
        applyStimulus(make_pkt(16'd80));
        checkOutput("probe_entry2_hit", 32'(hit_ex), 32'd1);
        checkOutput("probe_entry2_idx", 32'(idx_ex), 32'd2);

        // Reset in the middle of scanning chunk 1, with rule 7 about to hit.
        write_rule(4'd2, make_rule(16'd80, 16'd81), 1'b0);
        @(negedge clk);
        bus_ex.pkt       = make_pkt(16'd80);
        bus_ex.pkt_valid = 1'b1;
        bus_ex.res_ready = 1'b1;
        @(negedge clk);
        bus_ex.pkt_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midscan_pkt_ready", 32'(bus_ex.pkt_ready), 32'd1);
        checkOutput("midscan_cfg_ready", 32'(bus_ex.cfg_ready), 32'd1);
        checkOutput("midscan_res_valid", 32'(bus_ex.res_valid), 32'd0);
        checkOutput("midscan_res_hit", 32'(bus_ex.res_hit), 32'd0);
        checkOutput("midscan_res_idx", 32'(bus_ex.res_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("post_reset_no_valid", 32'(bus_ex.res_valid), 32'd0);
        end
        applyStimulus(make_pkt(16'd80));
        checkOutput("post_reset_hit", 32'(hit_ex), 32'd0);
        checkOutput("post_reset_lat", 32'(lat_ex), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
